// File: rtl/debug_feeder_pkg.sv
// Shared debug types: LED update record, colour codes, feeder depth and writer FSM states.
package debug_feeder_pkg;

   localparam int FEED_DEPTH_DEFAULT = 8;

   typedef enum logic [1:0] {Off, Red, Green, Blue} Color;

   typedef struct packed {
      logic [3:0] ledNo;
      Color       color;
      logic       status;
   } debugInfo_t;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} feed_state_e;

endpackage

// File: rtl/debug_feeder_fifo.sv
// Circular FIFO with occupancy count; a push is dropped when full and a pop is dropped when empty.
// o_count_nxt exposes next-cycle occupancy so the owner can register flow-control from it.
module debug_fifo
   import debug_feeder_pkg::*;
#(
   parameter int  DEPTH = FEED_DEPTH_DEFAULT,
   parameter type T     = debugInfo_t
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_push,
   input  T                        i_din,
   input  logic                    i_pop,
   output T                        o_dout,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic [$clog2(DEPTH):0]  o_count_nxt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      do_push  = i_push && (count_q != CW'(DEPTH));
      do_pop   = i_pop && (count_q != '0);
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible through the pointers.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= i_din;
      end
   end

   assign o_dout      = mem_q[rd_ptr_q];
   assign o_count     = count_q;
   assign o_count_nxt = count_d;

endmodule

// File: rtl/debug_feeder.sv
// Buffers LED debug updates and replays each one as a single-cycle active-low write toward visuMon.
// Writes go out at most one per 3 cycles; o_ready drops while the buffer holds FEED_DEPTH entries.
module debug_feeder
   import debug_feeder_pkg::*;
#(
   parameter int FEED_DEPTH = FEED_DEPTH_DEFAULT
) (
   input  logic                        i_clk25Mhz,
   input  logic                        i_reset,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  debugInfo_t                  i_debugInfo,
   output logic                        o_cs,
   output debugInfo_t                  o_debugInfo,
   output logic [$clog2(FEED_DEPTH):0] o_level,
   output logic                        o_busy
);

   localparam int LW = $clog2(FEED_DEPTH) + 1;

   feed_state_e   state_q, state_d;
   debugInfo_t    info_q, info_d;
   logic          ready_q, ready_d;
   logic [LW-1:0] seen_q, seen_d;
   logic [LW-1:0] count, count_nxt;
   logic          push, pop;
   debugInfo_t    head;

   debug_fifo #(
      .DEPTH (FEED_DEPTH),
      .T     (debugInfo_t)
   ) u_fifo (
      .i_clk       (i_clk25Mhz),
      .i_rst       (i_reset),
      .i_push      (push),
      .i_din       (i_debugInfo),
      .i_pop       (pop),
      .o_dout      (head),
      .o_count     (count),
      .o_count_nxt (count_nxt)
   );

   // The FSM decides on last cycle's occupancy (seen_q); pops are at least
   // three cycles apart, so this copy never claims an entry already taken.
   always_comb begin
      state_d = state_q;
      info_d  = info_q;
      pop     = 1'b0;
      push    = i_valid && ready_q;
      ready_d = (count_nxt != LW'(FEED_DEPTH));
      seen_d  = count;
      case (state_q)
         IDLE, HOLD: begin
            if (seen_q != '0) begin
               pop     = 1'b1;
               info_d  = head;
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP:   state_d = STROBE;
         STROBE:  state_d = HOLD;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk25Mhz or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         info_q  <= '0;
         ready_q <= 1'b0;
         seen_q  <= '0;
      end else begin
         state_q <= state_d;
         info_q  <= info_d;
         ready_q <= ready_d;
         seen_q  <= seen_d;
      end
   end

   assign o_cs        = (state_q != STROBE);
   assign o_debugInfo = info_q;
   assign o_ready     = ready_q;
   assign o_level     = count;
   assign o_busy      = (state_q != IDLE) || (count != '0);

endmodule

// File: tb/tb_debug_feeder.sv
// Directed bench for debug_feeder: reset, single write, burst, wrap at level 4, full, reset during strobe.
module tb_debug_feeder;
   import debug_feeder_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic       ready;
   debugInfo_t din = '0;
   logic       cs;
   debugInfo_t dout;
   logic [3:0] level;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      int         c;
      debugInfo_t d;
   } strobe_t;

   strobe_t    slog[$];
   debugInfo_t arrDebugInfo [16];
   debugInfo_t exp_q[$];

   debug_feeder dut (
      .i_clk25Mhz  (clk),
      .i_reset     (rst),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_debugInfo (din),
      .o_cs        (cs),
      .o_debugInfo (dout),
      .o_level     (level),
      .o_busy      (busy)
   );

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // visuMon model: latch the write on every low strobe cycle
   always @(negedge clk) begin
      if (!rst && cs === 1'b0) begin
         slog.push_back('{cyc, dout});
         arrDebugInfo[dout.ledNo] = dout;
      end
   end

   function automatic debugInfo_t mk(input int led, input int col, input int st);
      debugInfo_t r;
      r.ledNo  = 4'(led);
      r.color  = Color'(col % 4);
      r.status = st[0];
      return r;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      valid = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (cs !== 1'b1) begin fails++; $display("FAIL reset_cs: got %b expected 1", cs); end
      tests++; if (level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (dout !== 7'h00) begin fails++; $display("FAIL reset_info: got %h expected 00", dout); end
      rst = 1'b0;
      #1;
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL ready_pre_edge: got %b expected 0", ready); end
      @(negedge clk);
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge: got %b expected 1", ready); end
   endtask

   task automatic test_single;
      debugInfo_t d;
      int n;
      d = mk(1, 1, 1);
      @(negedge clk);
      valid = 1'b1; din = d; n = cyc + 1;
      @(negedge clk);
      valid = 1'b0;
      tests++; if (level !== 4'd1) begin fails++; $display("FAIL single_level: got %0d expected 1", level); end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         tests++;
         if (cs !== ((k == 3) ? 1'b0 : 1'b1)) begin
            fails++; $display("FAIL single_cs at N+%0d: got %b expected %b", k, cs, (k == 3) ? 1'b0 : 1'b1);
         end
         if (k >= 2 && k <= 5) begin
            tests++; if (dout !== d) begin fails++; $display("FAIL single_info at N+%0d: got %h expected %h", k, dout, d); end
         end
         if (k >= 5) begin
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy at N+%0d: got %b expected 0", k, busy); end
         end
      end
   endtask

   task automatic test_burst;
      debugInfo_t e [3];
      int s, n;
      e[0] = mk(1, 1, 1); e[1] = mk(2, 2, 0); e[2] = mk(3, 3, 1);
      s = slog.size();
      @(negedge clk);
      valid = 1'b1; din = e[0]; n = cyc + 1;
      @(negedge clk); din = e[1];
      @(negedge clk); din = e[2];
      @(negedge clk); valid = 1'b0;
      repeat (14) @(negedge clk);
      tests++;
      if (slog.size() - s != 3) begin
         fails++; $display("FAIL burst_count: got %0d expected 3", slog.size() - s);
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests++; if (slog[s+i].c != n + 3 + 3 * i) begin fails++; $display("FAIL burst_time[%0d]: got %0d expected %0d", i, slog[s+i].c, n + 3 + 3 * i); end
            tests++; if (slog[s+i].d !== e[i]) begin fails++; $display("FAIL burst_data[%0d]: got %h expected %h", i, slog[s+i].d, e[i]); end
            tests++; if (arrDebugInfo[i+1] !== e[i]) begin fails++; $display("FAIL burst_arr[%0d]: got %h expected %h", i + 1, arrDebugInfo[i+1], e[i]); end
         end
      end
   endtask

   task automatic test_wrap;
      int s, idx;
      logic pushing;
      s = slog.size();
      exp_q.delete();
      idx = 0;
      @(negedge clk);
      for (int j = 0; j <= 48; j++) begin
         if (j - 1 >= 4) begin
            tests++; if (level !== 4'd4) begin fails++; $display("FAIL wrap_level at N+%0d: got %0d expected 4", j - 1, level); end
         end
         pushing = (j <= 5) || (j >= 8 && j <= 47 && (j - 8) % 3 == 0);
         valid = pushing;
         if (pushing) begin
            din = mk(idx, idx, idx >> 4);
            exp_q.push_back(din);
            idx++;
         end
         @(negedge clk);
      end
      valid = 1'b0;
      repeat (20) @(negedge clk);
      tests++; if (level !== 4'd0) begin fails++; $display("FAIL wrap_drain: got %0d expected 0", level); end
      tests++;
      if (slog.size() - s != 20) begin
         fails++; $display("FAIL wrap_count: got %0d expected 20", slog.size() - s);
      end else begin
         for (int i = 0; i < 20; i++) begin
            tests++; if (slog[s+i].d !== exp_q[i]) begin fails++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, slog[s+i].d, exp_q[i]); end
         end
      end
   endtask

   task automatic test_full;
      int s, idx;
      logic saw_full;
      s = slog.size();
      exp_q.delete();
      idx = 0;
      saw_full = 1'b0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         tests++;
         if ((level == 4'd8) !== (ready == 1'b0)) begin
            fails++; $display("FAIL full_ready: level %0d with ready %b", level, ready);
         end
         if (level == 4'd8) saw_full = 1'b1;
         valid = 1'b1;
         din = mk(idx, idx + 1, idx);
         if (ready) begin
            exp_q.push_back(din);
            idx++;
         end
      end
      @(negedge clk);
      valid = 1'b0;
      repeat (45) @(negedge clk);
      tests++; if (saw_full !== 1'b1) begin fails++; $display("FAIL full_reached: got %b expected 1", saw_full); end
      tests++;
      if (slog.size() - s != exp_q.size()) begin
         fails++; $display("FAIL full_strobes: got %0d expected %0d", slog.size() - s, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            tests++; if (slog[s+i].d !== exp_q[i]) begin fails++; $display("FAIL full_order[%0d]: got %h expected %h", i, slog[s+i].d, exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_strobe;
      int snap;
      debugInfo_t d;
      @(negedge clk);
      valid = 1'b1; din = mk(5, 1, 0);
      @(negedge clk); din = mk(6, 2, 1);
      @(negedge clk); din = mk(7, 3, 0);
      @(negedge clk); din = mk(8, 0, 1);
      @(negedge clk); valid = 1'b0;
      tests++; if (cs !== 1'b0) begin fails++; $display("FAIL rs_in_strobe: got %b expected 0", cs); end
      tests++; if (level !== 4'd3) begin fails++; $display("FAIL rs_level: got %0d expected 3", level); end
      rst = 1'b1;
      #1;
      tests++; if (cs !== 1'b1) begin fails++; $display("FAIL rs_cs_async: got %b expected 1", cs); end
      tests++; if (level !== 4'd0) begin fails++; $display("FAIL rs_level_async: got %0d expected 0", level); end
      tests++; if (dout !== 7'h00) begin fails++; $display("FAIL rs_info: got %h expected 00", dout); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rs_busy: got %b expected 0", busy); end
      snap = slog.size();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      tests++; if (slog.size() != snap) begin fails++; $display("FAIL rs_no_strobe: got %0d expected %0d", slog.size(), snap); end
      tests++; if (level !== 4'd0) begin fails++; $display("FAIL rs_level_after: got %0d expected 0", level); end
      d = mk(9, 2, 1);
      valid = 1'b1; din = d;
      @(negedge clk); valid = 1'b0;
      repeat (8) @(negedge clk);
      tests++;
      if (slog.size() != snap + 1) begin
         fails++; $display("FAIL rs_recover_count: got %0d expected %0d", slog.size(), snap + 1);
      end else begin
         tests++; if (slog[snap].d !== d) begin fails++; $display("FAIL rs_recover_data: got %h expected %h", slog[snap].d, d); end
      end
   endtask

   initial begin
      #(40 * 20000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_wrap();
      test_full();
      test_reset_strobe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
